// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller
//   Steps the DDS tuning word (phase_M) through a programmed sweep: ramp up,
//   or up-then-down in triangle mode. Each point is held for max(dwell,1)
//   clocks. The config word is accepted only while idle.
//   Optional build macro SWEEP_REPEAT_EN adds cfg_repeat (repeat+1 passes).
module dds_sweep_controller #(
  parameter int M_W     = 13,
  parameter int A_W     = 11,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [M_W-1:0]     cfg_start_m,
  input  logic [M_W-1:0]     cfg_stop_m,
  input  logic [M_W-1:0]     cfg_step_m,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [A_W-1:0]     cfg_amp,
  input  logic [1:0]         cfg_shape,
  input  logic               cfg_mode,
`ifdef SWEEP_REPEAT_EN
  input  logic [7:0]         cfg_repeat,
`endif
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               m_update,
  output logic [M_W-1:0]     phase_M,
  output logic [A_W-1:0]     signal_A,
  output logic [1:0]         signal_shape
);

  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_DONE} state_t;

  state_t             state_reg, state_next;
  logic [M_W-1:0]     start_m_reg, stop_m_reg, step_m_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic [A_W-1:0]     amp_reg;
  logic [1:0]         shape_reg;
  logic               mode_reg;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [M_W-1:0]     phase_reg, phase_next;
  logic [A_W-1:0]     sig_a_reg, sig_a_next;
  logic [1:0]         shape_out_reg, shape_out_next;
  logic               m_upd_reg, m_upd_next;
  logic               err_reg, err_next;
  logic               pass_end;
  logic [DWELL_W-1:0] dwell_last;
  logic [M_W:0]       sum_up, diff_dn;
  logic               up_ok, down_ok, tc;
`ifdef SWEEP_REPEAT_EN
  logic [7:0]         repeat_reg, pass_reg, pass_next;
`endif

  // Dwell of 0 behaves as 1: terminal count is then reached every cycle.
  assign dwell_last = (dwell_reg == '0) ? '0 : dwell_reg - DWELL_W'(1);
  assign tc         = (cnt_reg == dwell_last);
  // Sums are one bit wider so a carry reads as "above stop" and a borrow is visible.
  assign sum_up     = {1'b0, phase_reg} + {1'b0, step_m_reg};
  assign diff_dn    = {1'b0, phase_reg} - {1'b0, step_m_reg};
  assign up_ok      = (step_m_reg != '0) && (sum_up <= {1'b0, stop_m_reg});
  assign down_ok    = !diff_dn[M_W] && (diff_dn[M_W-1:0] >= start_m_reg);

  // Config word capture; only possible while idle (cfg_ready).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_m_reg <= '0;
      stop_m_reg  <= '0;
      step_m_reg  <= '0;
      dwell_reg   <= '0;
      amp_reg     <= '0;
      shape_reg   <= '0;
      mode_reg    <= 1'b0;
`ifdef SWEEP_REPEAT_EN
      repeat_reg  <= '0;
`endif
    end else if (cfg_valid && cfg_ready) begin
      start_m_reg <= cfg_start_m;
      stop_m_reg  <= cfg_stop_m;
      step_m_reg  <= cfg_step_m;
      dwell_reg   <= cfg_dwell;
      amp_reg     <= cfg_amp;
      shape_reg   <= cfg_shape;
      mode_reg    <= cfg_mode;
`ifdef SWEEP_REPEAT_EN
      repeat_reg  <= cfg_repeat;
`endif
    end
  end

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      phase_reg     <= '0;
      sig_a_reg     <= '0;
      shape_out_reg <= '0;
      m_upd_reg     <= 1'b0;
      err_reg       <= 1'b0;
`ifdef SWEEP_REPEAT_EN
      pass_reg      <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      phase_reg     <= phase_next;
      sig_a_reg     <= sig_a_next;
      shape_out_reg <= shape_out_next;
      m_upd_reg     <= m_upd_next;
      err_reg       <= err_next;
`ifdef SWEEP_REPEAT_EN
      pass_reg      <= pass_next;
`endif
    end
  end

  // Next-state and next-datapath decode; abort overrides everything outside IDLE.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    phase_next     = phase_reg;
    sig_a_next     = sig_a_reg;
    shape_out_next = shape_out_reg;
    m_upd_next     = 1'b0;
    err_next       = 1'b0;
    pass_end       = 1'b0;
`ifdef SWEEP_REPEAT_EN
    pass_next      = pass_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          if (start_m_reg > stop_m_reg) begin
            err_next = 1'b1;
          end else begin
            state_next     = ST_UP;
            phase_next     = start_m_reg;
            sig_a_next     = amp_reg;
            shape_out_next = shape_reg;
            m_upd_next     = 1'b1;
            cnt_next       = '0;
`ifdef SWEEP_REPEAT_EN
            pass_next      = '0;
`endif
          end
        end
      end
      ST_UP: begin
        if (!tc) begin
          cnt_next = cnt_reg + DWELL_W'(1);
        end else begin
          cnt_next = '0;
          if (up_ok) begin
            phase_next = sum_up[M_W-1:0];
            m_upd_next = 1'b1;
          end else if (mode_reg && (phase_reg != start_m_reg)) begin
            state_next = ST_DOWN;
            phase_next = diff_dn[M_W-1:0];
            m_upd_next = 1'b1;
          end else begin
            pass_end = 1'b1;
          end
        end
      end
      ST_DOWN: begin
        if (!tc) begin
          cnt_next = cnt_reg + DWELL_W'(1);
        end else begin
          cnt_next = '0;
          if (down_ok) begin
            phase_next = diff_dn[M_W-1:0];
            m_upd_next = 1'b1;
          end else begin
            pass_end = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // End of a pass: either restart from start_m (more passes left) or finish.
    if (pass_end) begin
`ifdef SWEEP_REPEAT_EN
      if (pass_reg != repeat_reg) begin
        pass_next  = pass_reg + 8'd1;
        state_next = ST_UP;
        phase_next = start_m_reg;
        m_upd_next = 1'b1;
      end else begin
        state_next = ST_DONE;
      end
`else
      state_next = ST_DONE;
`endif
    end

    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      phase_next = '0;
      sig_a_next = '0;
      m_upd_next = 1'b1;
      err_next   = 1'b0;
    end
  end

  // Output decode from state and registered datapath.
  always_comb begin
    cfg_ready    = (state_reg == ST_IDLE);
    busy         = (state_reg == ST_UP) || (state_reg == ST_DOWN);
    done         = (state_reg == ST_DONE);
    cfg_err      = err_reg;
    m_update     = m_upd_reg;
    phase_M      = phase_reg;
    signal_A     = sig_a_reg;
    signal_shape = shape_out_reg;
  end

endmodule
